// File: rtl/pq_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// pq_access_ctrl_if
//
// Groups the three buses that pq_access_ctrl touches:
//   request stream  : i_req_valid, o_req_ready, i_req_op[1:0], i_req_data
//   response stream : o_rsp_valid, i_rsp_ready, o_rsp_data, o_rsp_err
//   queue port      : o_q_wrt, o_q_read, o_q_data  (controller -> queue)
//                     i_q_full, i_q_empty, i_q_data (queue -> controller)
// The i_/o_ prefixes are from the controller's point of view.
//
// Handshake semantics (both streams): a transfer happens on a rising clock
// edge where valid and ready are both 1. Once valid is raised, the producer
// holds valid and its payload stable until that transfer. Ready may be
// raised or dropped freely and never depends on valid.
//
// Modports:
//   slave  - the controller (consumes requests, produces responses, drives
//            the queue port)
//   master - the environment (produces requests, consumes responses,
//            models the queue)
// ---------------------------------------------------------------------------
interface pq_access_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  // Request stream
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic [1:0]            i_req_op;
  logic [DATA_WIDTH-1:0] i_req_data;

  // Response stream
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] o_rsp_data;
  logic                  o_rsp_err;

  // Queue push/pop port
  logic                  o_q_wrt;
  logic                  o_q_read;
  logic [DATA_WIDTH-1:0] o_q_data;
  logic                  i_q_full;
  logic                  i_q_empty;
  logic [DATA_WIDTH-1:0] i_q_data;

  modport slave (
    input  i_req_valid, i_req_op, i_req_data,
    input  i_rsp_ready,
    input  i_q_full, i_q_empty, i_q_data,
    output o_req_ready,
    output o_rsp_valid, o_rsp_data, o_rsp_err,
    output o_q_wrt, o_q_read, o_q_data
  );

  modport master (
    output i_req_valid, i_req_op, i_req_data,
    output i_rsp_ready,
    output i_q_full, i_q_empty, i_q_data,
    input  o_req_ready,
    input  o_rsp_valid, o_rsp_data, o_rsp_err,
    input  o_q_wrt, o_q_read, o_q_data
  );
endinterface

// File: rtl/pq_access_ctrl.sv
// ---------------------------------------------------------------------------
// pq_access_ctrl
//
// Initiator-side controller for the push/pop port of a register-array
// priority queue. Requests arrive on a valid/ready stream, each one issues
// at most one queue operation, and every request gets exactly one response
// on a valid/ready stream, in order. After a queue operation is issued the
// controller waits SETTLE_CYCLES cycles so the queue's odd/even sort can
// settle before the next request is accepted.
//
// Ops (i_req_op): 01 push, 10 pop, 11 replace (pop head + push data),
//                 00 illegal. Data value 0 is the queue's empty sentinel and
//                 can never be written.
//
// Ports:
//   i_CLK        clock
//   i_RST        asynchronous active-high reset
//   bus          pq_access_ctrl_if.slave: request, response and queue buses
//   o_dbg_state  current FSM state (0 IDLE, 1 ISSUE, 2 WAIT)
//   o_stat_push/o_stat_pop/o_stat_err (only with PQ_ACCESS_CTRL_STATS_EN)
//                16-bit saturating counts of write pulses, read pulses and
//                rejected requests
//
// Optional feature macro: PQ_ACCESS_CTRL_STATS_EN
//
// Timing: request accepted in cycle T, queue pulse in T+1 (ISSUE),
// o_rsp_valid from T+2 (WAIT).
// ---------------------------------------------------------------------------
module pq_access_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int QUEUE_SIZE    = 4,
  parameter int SETTLE_CYCLES = QUEUE_SIZE,
  parameter int ENQ_ENA       = 1
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  pq_access_ctrl_if.slave        bus,
  output logic [1:0]             o_dbg_state
`ifdef PQ_ACCESS_CTRL_STATS_EN
  ,
  output logic [15:0]            o_stat_push,
  output logic [15:0]            o_stat_pop,
  output logic [15:0]            o_stat_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam int              CNT_W     = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  // Elaboration-time parameter sanity checks.
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("pq_access_ctrl: SETTLE_CYCLES must be >= 1");
  end
  if (QUEUE_SIZE < 1) begin : g_bad_qsize
    $error("pq_access_ctrl: QUEUE_SIZE must be >= 1");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                state_q,     state_d;
  logic [1:0]            op_q,        op_d;
  logic [DATA_WIDTH-1:0] data_q,      data_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic                  rsp_err_q,   rsp_err_d;

  // Combinational outputs of the FSM
  logic                  req_ready;
  logic                  q_wrt;
  logic                  q_read;
  logic [DATA_WIDTH-1:0] q_data;

  // Op decode and legality of the registered op against the live queue flags
  logic op_writes;
  logic op_reads;
  logic data_nz;
  logic op_legal;
  logic rsp_hs;

  always_comb begin : decode
    op_writes = (op_q == OP_PUSH) || (op_q == OP_REPL);
    op_reads  = (op_q == OP_POP)  || (op_q == OP_REPL);
    data_nz   = |data_q;
    op_legal  = 1'b0;
    case (op_q)
      OP_PUSH: op_legal = (ENQ_ENA != 0) && !bus.i_q_full && data_nz;
      OP_POP:  op_legal = !bus.i_q_empty;
      // Replace never overflows (one out, one in) and on an empty queue it
      // simply returns the sentinel 0 as the old head.
      OP_REPL: op_legal = data_nz;
      default: op_legal = 1'b0;
    endcase
  end

  assign rsp_hs = rsp_valid_q && bus.i_rsp_ready;

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin : fsm_comb
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = 1'b0;
    q_wrt       = 1'b0;
    q_read      = 1'b0;
    q_data      = '0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (bus.i_req_valid) begin
          op_d    = bus.i_req_op;
          data_d  = bus.i_req_data;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        rsp_valid_d = 1'b1;
        state_d     = S_WAIT;
        if (op_legal) begin
          q_wrt      = op_writes;
          q_read     = op_reads;
          q_data     = op_writes ? data_q : '0;
          // Head is captured in the same cycle as the read pulse, i.e.
          // before the queue shifts.
          rsp_data_d = op_reads ? bus.i_q_data : '0;
          rsp_err_d  = 1'b0;
          cnt_d      = SETTLE_LD;
        end else begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          // Nothing was issued, so there is nothing to let settle.
          cnt_d      = '0;
        end
      end

      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
        end
        // A response taken in this very cycle counts as consumed.
        if ((cnt_q == '0) && (!rsp_valid_q || rsp_hs)) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_CLK or posedge i_RST) begin : fsm_seq
    if (i_RST) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      data_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // The state register already sits in IDLE while reset is held, so ready is
  // masked explicitly to keep the request stream closed during reset.
  assign bus.o_req_ready = req_ready && !i_RST;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_q_wrt     = q_wrt;
  assign bus.o_q_read    = q_read;
  assign bus.o_q_data    = q_data;
  assign o_dbg_state     = state_q;

`ifdef PQ_ACCESS_CTRL_STATS_EN
  // -------------------------------------------------------------------------
  // Saturating activity counters
  // -------------------------------------------------------------------------
  logic [15:0] stat_push_q;
  logic [15:0] stat_pop_q;
  logic [15:0] stat_err_q;
  logic        issue_rej;

  assign issue_rej = (state_q == S_ISSUE) && !op_legal;

  always_ff @(posedge i_CLK or posedge i_RST) begin : stats_seq
    if (i_RST) begin
      stat_push_q <= '0;
      stat_pop_q  <= '0;
      stat_err_q  <= '0;
    end else begin
      if (q_wrt && (stat_push_q != 16'hFFFF)) begin
        stat_push_q <= stat_push_q + 16'd1;
      end
      if (q_read && (stat_pop_q != 16'hFFFF)) begin
        stat_pop_q <= stat_pop_q + 16'd1;
      end
      if (issue_rej && (stat_err_q != 16'hFFFF)) begin
        stat_err_q <= stat_err_q + 16'd1;
      end
    end
  end

  assign o_stat_push = stat_push_q;
  assign o_stat_pop  = stat_pop_q;
  assign o_stat_err  = stat_err_q;
`endif

endmodule

// File: tb/tb_pq_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pq_access_ctrl
//
// Directed bench for pq_access_ctrl (QUEUE_SIZE=4, SETTLE_CYCLES=4). A small
// behavioural priority queue (largest value at the head, capacity 4) sits on
// the queue port. Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_pq_access_ctrl;

  localparam int DW = 16;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic i_CLK = 1'b0;
  logic i_RST = 1'b1;
  always #5 i_CLK = ~i_CLK;

  int cyc = 0;
  always @(posedge i_CLK) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  pq_access_ctrl_if #(.DATA_WIDTH(DW)) bus ();
  logic [1:0] dbg_state;

`ifdef PQ_ACCESS_CTRL_STATS_EN
  logic [15:0] stat_push, stat_pop, stat_err;
`endif

  pq_access_ctrl #(
    .DATA_WIDTH   (DW),
    .QUEUE_SIZE   (4),
    .SETTLE_CYCLES(4),
    .ENQ_ENA      (1)
  ) dut (
    .i_CLK      (i_CLK),
    .i_RST      (i_RST),
    .bus        (bus),
    .o_dbg_state(dbg_state)
`ifdef PQ_ACCESS_CTRL_STATS_EN
    ,
    .o_stat_push(stat_push),
    .o_stat_pop (stat_pop),
    .o_stat_err (stat_err)
`endif
  );

  // -------------------------------------------------------------------------
  // Behavioural queue + pulse monitor
  // -------------------------------------------------------------------------
  logic [DW-1:0] qm[$];
  logic          m_full  = 1'b0;
  logic          m_empty = 1'b1;
  logic [DW-1:0] m_head  = '0;
  assign bus.i_q_full  = m_full;
  assign bus.i_q_empty = m_empty;
  assign bus.i_q_data  = m_head;

  logic          pend_wrt = 1'b0;
  logic          pend_rd  = 1'b0;
  logic [DW-1:0] pend_data = '0;
  int            wrt_n = 0, rd_n = 0, both_n = 0, bad_pulse_n = 0;
  int            wrt_cyc = -1, rd_cyc = -1;
  logic [DW-1:0] wrt_data = '0;

  always @(negedge i_CLK) begin
    pend_wrt  = bus.o_q_wrt;
    pend_rd   = bus.o_q_read;
    pend_data = bus.o_q_data;
    if (bus.o_q_wrt)  begin wrt_n++; wrt_cyc = cyc; wrt_data = bus.o_q_data; end
    if (bus.o_q_read) begin rd_n++;  rd_cyc  = cyc; end
    if (bus.o_q_wrt && bus.o_q_read) both_n++;
    if ((bus.o_q_wrt || bus.o_q_read) && dbg_state != 2'd1) bad_pulse_n++;
  end

  always @(posedge i_CLK) begin
    int k;
    if (pend_rd && qm.size() > 0) void'(qm.pop_front());
    if (pend_wrt && qm.size() < 4) begin
      k = 0;
      while (k < qm.size() && qm[k] >= pend_data) k++;
      qm.insert(k, pend_data);
    end
    pend_wrt = 1'b0;
    pend_rd  = 1'b0;
    m_full  <= (qm.size() == 4);
    m_empty <= (qm.size() == 0);
    m_head  <= (qm.size() > 0) ? qm[0] : '0;
  end

  // -------------------------------------------------------------------------
  // Driver: one full request/response transaction with immediate rsp_ready
  // -------------------------------------------------------------------------
  task automatic do_req(input logic [1:0] op, input logic [DW-1:0] d,
                        output int acc, output int rc, output int hs,
                        output logic [DW-1:0] rd, output logic re);
    int n;
    n = 0;
    while (bus.o_req_ready !== 1'b1 && n < 100) begin @(negedge i_CLK); n++; end
    checks++;
    if (n >= 100) begin fails++; $display("FAIL req_ready_timeout: got 0 required 1"); end
    bus.i_req_valid = 1'b1;
    bus.i_req_op    = op;
    bus.i_req_data  = d;
    acc = cyc;
    @(negedge i_CLK);
    bus.i_req_valid = 1'b0;
    bus.i_req_op    = 2'b00;
    bus.i_req_data  = '0;
    n = 0;
    while (bus.o_rsp_valid !== 1'b1 && n < 100) begin @(negedge i_CLK); n++; end
    checks++;
    if (n >= 100) begin fails++; $display("FAIL rsp_valid_timeout: got 0 required 1"); end
    rc = cyc;
    rd = bus.o_rsp_data;
    re = bus.o_rsp_err;
    bus.i_rsp_ready = 1'b1;
    hs = cyc;
    @(negedge i_CLK);
    bus.i_rsp_ready = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    repeat (2) @(negedge i_CLK);
    checks++; if (bus.o_req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready: got %b required 0", bus.o_req_ready); end
    checks++; if (bus.o_rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b required 0", bus.o_rsp_valid); end
    checks++; if (bus.o_rsp_data !== 16'h0) begin fails++; $display("FAIL rst_rsp_data: got %h required 0", bus.o_rsp_data); end
    checks++; if (bus.o_rsp_err !== 1'b0) begin fails++; $display("FAIL rst_rsp_err: got %b required 0", bus.o_rsp_err); end
    checks++; if (bus.o_q_wrt !== 1'b0 || bus.o_q_read !== 1'b0) begin fails++; $display("FAIL rst_q_pulse: got wrt=%b read=%b required 0 0", bus.o_q_wrt, bus.o_q_read); end
    checks++; if (bus.o_q_data !== 16'h0) begin fails++; $display("FAIL rst_q_data: got %h required 0", bus.o_q_data); end
    checks++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL rst_state: got %0d required 0", dbg_state); end
    i_RST = 1'b0;
    @(negedge i_CLK);
    checks++; if (bus.o_req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b required 1", bus.o_req_ready); end
  endtask

  task automatic test_push_pop();
    int a1, a2, a3, rc, hs, w0;
    logic [DW-1:0] rd;
    logic re;
    w0 = wrt_n;
    do_req(2'b01, 16'd5, a1, rc, hs, rd, re);
    checks++; if (re !== 1'b0) begin fails++; $display("FAIL push5_err: got %b required 0", re); end
    checks++; if (rd !== 16'd0) begin fails++; $display("FAIL push5_data: got %0d required 0", rd); end
    checks++; if (wrt_cyc !== a1 + 1) begin fails++; $display("FAIL push5_pulse_cycle: got %0d required %0d", wrt_cyc, a1 + 1); end
    checks++; if (rc !== a1 + 2) begin fails++; $display("FAIL push5_rsp_latency: got %0d required %0d", rc, a1 + 2); end
    checks++; if (wrt_data !== 16'd5) begin fails++; $display("FAIL push5_q_data: got %0d required 5", wrt_data); end
    do_req(2'b01, 16'd9, a2, rc, hs, rd, re);
    checks++; if (re !== 1'b0) begin fails++; $display("FAIL push9_err: got %b required 0", re); end
    checks++; if (wrt_n !== w0 + 2) begin fails++; $display("FAIL push_pulse_count: got %0d required %0d", wrt_n - w0, 2); end
    checks++; if (a2 - a1 < 6) begin fails++; $display("FAIL push_spacing: got %0d required >=6", a2 - a1); end
    do_req(2'b10, 16'd0, a3, rc, hs, rd, re);
    checks++; if (rd !== 16'd9 || re !== 1'b0) begin fails++; $display("FAIL pop9: got data=%0d err=%b required 9 0", rd, re); end
    checks++; if (rd_cyc !== a3 + 1) begin fails++; $display("FAIL pop9_pulse_cycle: got %0d required %0d", rd_cyc, a3 + 1); end
    checks++; if (a3 - a2 < 6) begin fails++; $display("FAIL pop_spacing: got %0d required >=6", a3 - a2); end
    do_req(2'b10, 16'd0, a1, rc, hs, rd, re);
    checks++; if (rd !== 16'd5 || re !== 1'b0) begin fails++; $display("FAIL pop5: got data=%0d err=%b required 5 0", rd, re); end
  endtask

  task automatic test_pop_empty();
    int a, rc, hs, r0, rdy_cyc;
    logic [DW-1:0] rd;
    logic re;
    r0 = rd_n;
    do_req(2'b10, 16'd0, a, rc, hs, rd, re);
    checks++; if (rd !== 16'd0 || re !== 1'b1) begin fails++; $display("FAIL pop_empty_rsp: got data=%0d err=%b required 0 1", rd, re); end
    checks++; if (rd_n !== r0) begin fails++; $display("FAIL pop_empty_pulse: got %0d reads required 0", rd_n - r0); end
    rdy_cyc = -1;
    for (int k = 0; k < 8 && rdy_cyc < 0; k++) begin
      if (bus.o_req_ready === 1'b1) rdy_cyc = cyc;
      else @(negedge i_CLK);
    end
    checks++; if (rdy_cyc < 0 || rdy_cyc > hs + 2) begin fails++; $display("FAIL pop_empty_ready_return: got cycle %0d required <= %0d", rdy_cyc, hs + 2); end
  endtask

  task automatic test_full();
    int a, rc, hs, w0;
    logic [DW-1:0] rd;
    logic re;
    logic [DW-1:0] pushes[4];
    logic [DW-1:0] pops[4];
    pushes = '{16'd3, 16'd7, 16'd1, 16'd4};
    pops   = '{16'd7, 16'd4, 16'd3, 16'd1};
    for (int i = 0; i < 4; i++) begin
      do_req(2'b01, pushes[i], a, rc, hs, rd, re);
      checks++; if (re !== 1'b0) begin fails++; $display("FAIL fill_err_%0d: got %b required 0", i, re); end
    end
    w0 = wrt_n;
    do_req(2'b01, 16'd8, a, rc, hs, rd, re);
    checks++; if (re !== 1'b1 || rd !== 16'd0) begin fails++; $display("FAIL push_full: got err=%b data=%0d required 1 0", re, rd); end
    checks++; if (wrt_n !== w0) begin fails++; $display("FAIL push_full_pulse: got %0d writes required 0", wrt_n - w0); end
    for (int i = 0; i < 4; i++) begin
      do_req(2'b10, 16'd0, a, rc, hs, rd, re);
      checks++; if (rd !== pops[i] || re !== 1'b0) begin fails++; $display("FAIL drain_pop_%0d: got data=%0d err=%b required %0d 0", i, rd, re, pops[i]); end
    end
  endtask

  task automatic test_replace();
    int a, rc, hs, b0, w0;
    logic [DW-1:0] rd;
    logic re;
    do_req(2'b01, 16'd7, a, rc, hs, rd, re);
    do_req(2'b01, 16'd4, a, rc, hs, rd, re);
    b0 = both_n;
    do_req(2'b11, 16'd6, a, rc, hs, rd, re);
    checks++; if (rd !== 16'd7 || re !== 1'b0) begin fails++; $display("FAIL replace6: got data=%0d err=%b required 7 0", rd, re); end
    checks++; if (both_n !== b0 + 1) begin fails++; $display("FAIL replace_both_pulse: got %0d required 1", both_n - b0); end
    checks++; if (wrt_data !== 16'd6) begin fails++; $display("FAIL replace_q_data: got %0d required 6", wrt_data); end
    do_req(2'b10, 16'd0, a, rc, hs, rd, re);
    checks++; if (rd !== 16'd6) begin fails++; $display("FAIL pop_after_replace: got %0d required 6", rd); end
    do_req(2'b10, 16'd0, a, rc, hs, rd, re);
    checks++; if (rd !== 16'd4) begin fails++; $display("FAIL pop_after_replace2: got %0d required 4", rd); end
    // Replace on an empty queue returns the sentinel without error.
    do_req(2'b11, 16'd2, a, rc, hs, rd, re);
    checks++; if (rd !== 16'd0 || re !== 1'b0) begin fails++; $display("FAIL replace_empty: got data=%0d err=%b required 0 0", rd, re); end
    w0 = wrt_n;
    do_req(2'b11, 16'd0, a, rc, hs, rd, re);
    checks++; if (re !== 1'b1 || wrt_n !== w0) begin fails++; $display("FAIL replace_zero: got err=%b writes=%0d required 1 0", re, wrt_n - w0); end
    do_req(2'b10, 16'd0, a, rc, hs, rd, re);
    checks++; if (rd !== 16'd2 || re !== 1'b0) begin fails++; $display("FAIL pop_replaced_2: got data=%0d err=%b required 2 0", rd, re); end
  endtask

  task automatic test_backpressure();
    int a, rc, hs, n, w0;
    logic [DW-1:0] rd;
    logic re;
    do_req(2'b01, 16'd5, a, rc, hs, rd, re);
    n = 0;
    while (bus.o_req_ready !== 1'b1 && n < 100) begin @(negedge i_CLK); n++; end
    bus.i_req_valid = 1'b1; bus.i_req_op = 2'b10; bus.i_req_data = '0;
    @(negedge i_CLK);
    bus.i_req_valid = 1'b0; bus.i_req_op = 2'b00;
    n = 0;
    while (bus.o_rsp_valid !== 1'b1 && n < 100) begin @(negedge i_CLK); n++; end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== 16'd5 || bus.o_req_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_stable_%0d: got valid=%b data=%0d ready=%b required 1 5 0", k, bus.o_rsp_valid, bus.o_rsp_data, bus.o_req_ready);
      end
      @(negedge i_CLK);
    end
    bus.i_rsp_ready = 1'b1;
    @(negedge i_CLK);
    bus.i_rsp_ready = 1'b0;
    checks++; if (bus.o_rsp_valid !== 1'b0) begin fails++; $display("FAIL hold_valid_clear: got %b required 0", bus.o_rsp_valid); end
    w0 = wrt_n;
    do_req(2'b01, 16'd0, a, rc, hs, rd, re);
    checks++; if (re !== 1'b1 || rd !== 16'd0) begin fails++; $display("FAIL push_zero: got err=%b data=%0d required 1 0", re, rd); end
    do_req(2'b00, 16'd3, a, rc, hs, rd, re);
    checks++; if (re !== 1'b1 || rd !== 16'd0) begin fails++; $display("FAIL op_illegal: got err=%b data=%0d required 1 0", re, rd); end
    checks++; if (wrt_n !== w0) begin fails++; $display("FAIL rejected_no_pulse: got %0d writes required 0", wrt_n - w0); end
  endtask

  task automatic test_reset_mid();
    int n, w0, a, rc, hs;
    logic [DW-1:0] rd;
    logic re;
    w0 = wrt_n;
    n = 0;
    while (bus.o_req_ready !== 1'b1 && n < 100) begin @(negedge i_CLK); n++; end
    bus.i_req_valid = 1'b1; bus.i_req_op = 2'b01; bus.i_req_data = 16'd5;
    @(negedge i_CLK);
    bus.i_req_valid = 1'b0; bus.i_req_op = 2'b00; bus.i_req_data = '0;
    n = 0;
    while (bus.o_rsp_valid !== 1'b1 && n < 100) begin @(negedge i_CLK); n++; end
    @(negedge i_CLK);
    i_RST = 1'b1;
    #1;
    checks++; if (bus.o_rsp_valid !== 1'b0 || bus.o_rsp_data !== 16'd0 || bus.o_rsp_err !== 1'b0) begin fails++; $display("FAIL midrst_rsp: got valid=%b data=%0d err=%b required 0 0 0", bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_err); end
    checks++; if (bus.o_req_ready !== 1'b0) begin fails++; $display("FAIL midrst_ready: got %b required 0", bus.o_req_ready); end
    checks++; if (bus.o_q_wrt !== 1'b0 || bus.o_q_read !== 1'b0 || bus.o_q_data !== 16'd0) begin fails++; $display("FAIL midrst_q: got wrt=%b read=%b data=%0d required 0 0 0", bus.o_q_wrt, bus.o_q_read, bus.o_q_data); end
    @(negedge i_CLK);
    @(negedge i_CLK);
    i_RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_CLK);
      checks++;
      if (bus.o_req_ready !== 1'b1 || bus.o_rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL postrst_idle_%0d: got ready=%b valid=%b required 1 0", k, bus.o_req_ready, bus.o_rsp_valid);
      end
    end
    checks++; if (wrt_n !== w0 + 1) begin fails++; $display("FAIL midrst_pulse_count: got %0d required 1", wrt_n - w0); end
    do_req(2'b10, 16'd0, a, rc, hs, rd, re);
    checks++; if (rd !== 16'd5 || re !== 1'b0) begin fails++; $display("FAIL postrst_pop: got data=%0d err=%b required 5 0", rd, re); end
  endtask

  // -------------------------------------------------------------------------
  // Sequence + report
  // -------------------------------------------------------------------------
  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_req_op    = 2'b00;
    bus.i_req_data  = '0;
    bus.i_rsp_ready = 1'b0;
    test_reset();
    test_push_pop();
    test_pop_empty();
    test_full();
    test_replace();
    test_backpressure();
    test_reset_mid();
    checks++; if (bad_pulse_n !== 0) begin fails++; $display("FAIL pulse_outside_issue: got %0d required 0", bad_pulse_n); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
